stack_arbiter: RTL and testbench

Shares the single operand stack between two requesters, e.g. the instruction-sequencer port (A) and the debug/load port (B). It arbitrates round-robin and drives the stack's push/pop strobes. It keeps the authoritative occupancy count, blocks overflow and underflow, and returns pop data through a registered response. It sits directly in front of the stack datapath; only this block drives the stack's push, pop and data-in pins.

---
 rtl/stack_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/stack_arbiter.sv | 115 +++++++++++
 tb/tb_stack_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-requester operand-stack arbiter.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POP_WAIT = 2'd1,
    POP_RESP = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; one-hot grant, pointer remembers the last winner.
module rr_arbiter2
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && req_i[1]) begin
        gnt_o = (last_q == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) last_d = REQ_A;
    if (gnt_o[1]) last_d = REQ_B;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= REQ_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates push/pop access to one operand stack between requesters A and B.
// Owns occupancy, rejects overflow/underflow, returns pop data two cycles after grant.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_op,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             b_req,
  input  logic             b_op,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_err,
  output logic             b_err,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [N:0]       count,
  output logic             empty,
  output logic             full
);

  localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [N:0]       count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             owner_q, owner_d;

  logic [1:0]       gnt;
  logic             any_gnt, sel_op, do_push, do_pop, rej;
  logic [WIDTH-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == IDLE),
    .req_i ({b_req, a_req}),
    .gnt_o (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel_op    = gnt[1] ? b_op    : a_op;
  assign sel_wdata = gnt[1] ? b_wdata : a_wdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // Guards use the pre-edge count, so a rejected op never touches the stack.
  assign do_push = any_gnt && (sel_op == OP_PUSH) && !full;
  assign do_pop  = any_gnt && (sel_op == OP_POP)  && !empty;
  assign rej     = any_gnt && !do_push && !do_pop;

  assign a_gnt    = gnt[0];
  assign b_gnt    = gnt[1];
  assign a_err    = gnt[0] && rej;
  assign b_err    = gnt[1] && rej;
  assign stk_push = do_push;
  assign stk_pop  = do_pop;
  assign stk_din  = do_push ? sel_wdata : '0;

  assign a_rvalid = (state_q == POP_RESP) && (owner_q == REQ_A);
  assign b_rvalid = (state_q == POP_RESP) && (owner_q == REQ_B);
  assign rdata    = rdata_q;
  assign count    = count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (do_push) count_d = count_q + 1'b1;
        if (do_pop) begin
          count_d = count_q - 1'b1;
          owner_d = gnt[1] ? REQ_B : REQ_A;
          state_d = POP_WAIT;
        end
      end
      POP_WAIT: begin
        rdata_d = stk_dout;
        state_d = POP_RESP;
      end
      POP_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
      owner_q <= REQ_A;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack, reference-stack scoreboard, vector table.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
  logic       a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid;
  logic [7:0] rdata, stk_din, stk_dout;
  logic       stk_push, stk_pop;
  logic [8:0] count;
  logic       empty, full;

  stack_arbiter #(.WIDTH(8), .DEPTH(256), .N(8)) dut (
    .clk(clk), .reset(rst_n),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_err(a_err), .b_err(b_err),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural stack: top appears on stk_dout the cycle after a pop.
  logic [7:0] mem [0:255];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= 0;
      stk_dout <= 8'h00;
    end else if (stk_push && sp < 256) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  typedef struct {
    logic       owner;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic [7:0] ref_q[$];
  exp_t       exp_q[$];

  // Monitor: inputs change 1 time unit after posedge, everything sampled at negedge.
  always @(negedge clk) begin
    logic       sb, op, rq, e_push, e_pop;
    logic [7:0] wd;
    exp_t       e;
    if (!rst_n) begin
      ref_q.delete();
      exp_q.delete();
    end else begin
      check("count", 32'(count), 32'(ref_q.size()));
      check("empty", 32'(empty), 32'(ref_q.size() == 0));
      check("full", 32'(full), 32'(ref_q.size() == 256));
      check("gnt_onehot", 32'(a_gnt & b_gnt), 0);
      check("strobe_excl", 32'(stk_push & stk_pop), 0);
      if (a_gnt || b_gnt) begin
        sb = b_gnt;
        op = sb ? b_op : a_op;
        wd = sb ? b_wdata : a_wdata;
        rq = sb ? b_req : a_req;
        e_push = (op == 1'b0) && (ref_q.size() < 256);
        e_pop  = (op == 1'b1) && (ref_q.size() > 0);
        check("gnt_without_req", 32'(rq), 1);
        check("gnt_while_pop_busy", 32'(exp_q.size()), 0);
        check("stk_push", 32'(stk_push), 32'(e_push));
        check("stk_pop", 32'(stk_pop), 32'(e_pop));
        check("err", 32'(sb ? b_err : a_err), 32'(!(e_push || e_pop)));
        check("err_other", 32'(sb ? a_err : b_err), 0);
        if (e_push) begin
          check("stk_din", 32'(stk_din), 32'(wd));
          ref_q.push_back(wd);
        end
        if (e_pop) begin
          exp_q.push_back('{owner: sb, data: ref_q[ref_q.size()-1], due: cyc + 2});
          void'(ref_q.pop_back());
        end
      end else begin
        check("idle_strobes", 32'({stk_push, stk_pop, a_err, b_err}), 0);
      end
      if (a_rvalid || b_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_spurious", 32'({a_rvalid, b_rvalid}), 0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_a", 32'(a_rvalid), 32'(!e.owner));
          check("rvalid_b", 32'(b_rvalid), 32'(e.owner));
          check("rdata", 32'(rdata), 32'(e.data));
          check("rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("rvalid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic side, input logic op, input logic [7:0] d, output logic err);
    logic got;
    @(posedge clk); #1;
    if (side) begin b_req = 1'b1; b_op = op; b_wdata = d; end
    else      begin a_req = 1'b1; a_op = op; a_wdata = d; end
    got = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (side ? b_gnt : a_gnt) begin
        got = 1'b1;
        err = side ? b_err : a_err;
      end
    end
    if (!got) check("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (side) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       side;
    logic       op;
    logic [7:0] data;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic err;
    int   got;

    vecs[0]  = '{1'b0, 1'b0, 8'h11, 1'b0, 2};
    vecs[1]  = '{1'b0, 1'b0, 8'h22, 1'b0, 3};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b1, 8'h00, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 0};
    vecs[7]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b0, 8'h66, 1'b0, 2};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 0};

    // Reset values.
    idle(2);
    check("rst_count", 32'(count), 0);
    check("rst_flags", 32'({empty, full}), 32'(2'b10));
    check("rst_rdata", 32'(rdata), 0);
    check("rst_outs", 32'({a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid, stk_push, stk_pop, stk_din}), 0);
    rst_n = 1'b1;

    // Single push from A.
    idle(1);
    a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h3C;
    @(negedge clk);
    check("push_gnt", 32'({a_gnt, stk_push}), 32'(2'b11));
    check("push_din", 32'(stk_din), 32'h3C);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check("push_count", 32'(count), 1);
    check("push_empty", 32'(empty), 0);

    // Vector table: push/pop latency, underflow rejection, LIFO order.
    foreach (vecs[k]) begin
      do_op(vecs[k].side, vecs[k].op, vecs[k].data, err);
      check($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
      idle(3);
      @(negedge clk);
      check($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].exp_cnt));
    end

    // Tie from reset: A wins first, then strict alternation.
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h01;
    b_req = 1'b1; b_op = 1'b0; b_wdata = 8'h81;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_winner%0d", k), 32'({a_gnt, b_gnt}), (k % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
      @(posedge clk); #1;
      if (a_gnt) a_wdata = a_wdata + 8'h01;
      if (b_gnt) b_wdata = b_wdata + 8'h01;
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("rr_count", 32'(count), 4);

    // B waits out the pop response window.
    @(posedge clk); #1;
    a_req = 1'b1; a_op = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (a_gnt) got = 1;
    end
    check("stall_pop_gnt", 32'(got), 1);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b1; b_op = 1'b0; b_wdata = 8'hB0;
    @(negedge clk);
    check("stall_t1", 32'(b_gnt), 0);
    @(negedge clk);
    check("stall_t2", 32'(b_gnt), 0);
    @(negedge clk);
    check("stall_t3", 32'(b_gnt), 1);
    @(posedge clk); #1;
    b_req = 1'b0;

    // Fill to capacity, then overflow.
    a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h00;
    got = 0;
    for (int i = 0; i < 400 && got < 252; i++) begin
      @(negedge clk);
      if (a_gnt) got++;
      @(posedge clk); #1;
      a_wdata = 8'(got);
    end
    check("fill_grants", 32'(got), 252);
    @(negedge clk);
    check("ovf_gnt_err", 32'({a_gnt, a_err, stk_push}), 32'(3'b110));
    check("ovf_full", 32'(full), 1);
    check("ovf_count", 32'(count), 256);
    @(posedge clk); #1;
    a_req = 1'b0;

    do_op(1'b1, 1'b1, 8'h00, err);
    check("pop_at_full_err", 32'(err), 0);
    idle(3);

    // Reset while the pop is in POP_WAIT.
    @(posedge clk); #1;
    a_req = 1'b1; a_op = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (a_gnt) got = 1;
    end
    check("midpop_gnt", 32'(got), 1);
    @(posedge clk); #1;
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midpop_count", 32'(count), 0);
    check("midpop_flags", 32'({empty, full}), 32'(2'b10));
    check("midpop_rdata", 32'(rdata), 0);
    check("midpop_outs", 32'({a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid, stk_push, stk_pop}), 0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("midpop_no_rvalid%0d", i), 32'({a_rvalid, b_rvalid}), 0);
    end
    check("final_pending", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
